// File: rtl/aes_spi_slave_ctrl.sv
// SPI-style slave front end for an external AES cipher core.
// A frame carries CMD, TEXT and optionally KEY (MSB-first). The block then
// launches the core. It returns the result behind a single '1' marker bit,
// so the master only has to watch miso and never needs the core latency.
module aes_spi_slave_ctrl #(
   parameter  int Nk = 4,
   localparam int KW = 32 * Nk
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          mosi,
   output logic          miso,
   output logic          core_start,
   output logic          core_mode,
   output logic [127:0]  core_text,
   output logic [KW-1:0] core_key,
   input  logic          core_done,
   input  logic [127:0]  core_result,
   output logic          busy,
   output logic          err
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_TEXT, S_KEY, S_START, S_WAIT, S_MARK, S_SEND, S_HOLD, S_ERR
   } state_t;

   localparam logic [8:0] CMD_LAST  = 9'd7;
   localparam logic [8:0] TEXT_LAST = 9'd127;
   localparam logic [8:0] KEY_LAST  = 9'(KW - 1);

   state_t       state;
   state_t       state_nx;
   logic [8:0]   bit_cnt;
   logic [7:0]   cmd_sr;
   logic [7:0]   cmd_full;
   logic [127:0] text_sr;
   logic [127:0] result_sr;
   logic         key_valid;
   logic         cs_prev;
   logic         err_q;

   assign cmd_full   = {cmd_sr[6:0], mosi};
   assign core_start = (state == S_START);
   assign miso       = (state == S_MARK) || ((state == S_SEND) && result_sr[127]);
   assign busy       = (state != S_IDLE) && (state != S_HOLD);
   assign err        = err_q;

   // State register; reset drops straight back to IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; cs going high outranks everything outside IDLE
   always_comb begin
      state_nx = state;
      if ((state != S_IDLE) && cs) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (!cs && cs_prev) state_nx = S_CMD;
            S_CMD: begin
               if (bit_cnt == CMD_LAST) begin
                  if (cmd_full[5:0] != 6'd0)        state_nx = S_ERR;
                  else if (cmd_full[6] && !key_valid) state_nx = S_ERR;
                  else                              state_nx = S_TEXT;
               end
            end
            S_TEXT:  if (bit_cnt == TEXT_LAST) state_nx = cmd_sr[6] ? S_START : S_KEY;
            S_KEY:   if (bit_cnt == KEY_LAST) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT:  if (core_done) state_nx = S_MARK;
            S_MARK:  state_nx = S_SEND;
            S_SEND:  if (bit_cnt == TEXT_LAST) state_nx = S_HOLD;
            S_HOLD:  state_nx = S_HOLD;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Datapath: shift registers, field counter, key bookkeeping and core handoff
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_prev   <= 1'b0;
         bit_cnt   <= 9'd0;
         cmd_sr    <= 8'd0;
         text_sr   <= 128'd0;
         result_sr <= 128'd0;
         key_valid <= 1'b0;
         err_q     <= 1'b0;
         core_mode <= 1'b0;
         core_text <= 128'd0;
         core_key  <= '0;
      end else begin
         cs_prev <= cs;

         if ((state == S_IDLE) || (state_nx != state))
            bit_cnt <= ((state == S_IDLE) && (state_nx == S_CMD)) ? 9'd1 : 9'd0;
         else if ((state == S_CMD) || (state == S_TEXT) || (state == S_KEY) || (state == S_SEND))
            bit_cnt <= bit_cnt + 9'd1;

         if (((state == S_IDLE) && (state_nx == S_CMD)) || ((state == S_CMD) && !cs))
            cmd_sr <= cmd_full;

         if ((state == S_TEXT) && !cs)
            text_sr <= {text_sr[126:0], mosi};

         if ((state == S_KEY) && !cs)
            core_key <= {core_key[KW-2:0], mosi};

         if ((state == S_TEXT) && (state_nx == S_KEY))
            key_valid <= 1'b0;
         else if ((state == S_KEY) && (state_nx == S_START))
            key_valid <= 1'b1;

         if (state_nx == S_START) begin
            core_mode <= cmd_sr[7];
            core_text <= (state == S_TEXT) ? {text_sr[126:0], mosi} : text_sr;
         end

         if ((state == S_WAIT) && (state_nx == S_MARK))
            result_sr <= core_result;
         else if (state == S_SEND)
            result_sr <= {result_sr[126:0], 1'b0};

         if ((state == S_IDLE) && (state_nx == S_CMD))
            err_q <= 1'b0;
         else if ((state_nx == S_ERR) && (state != S_ERR))
            err_q <= 1'b1;
      end
   end

endmodule
